// File: rtl/max3421e_spi_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | max3421e_spi_sequencer_if: request/response and SPI-core register bus      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface max3421e_spi_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_reg;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [7:0]  rsp_status;
  logic        rsp_err;
  logic        spi_select;
  logic [2:0]  spi_mem_addr;
  logic        spi_read_n;
  logic        spi_write_n;
  logic [15:0] spi_wdata;
  logic [15:0] spi_rdata;
  logic        spi_dataavailable;

  // Sequencer side
  modport slave (
    input  req_valid, req_write, req_reg, req_wdata, spi_rdata, spi_dataavailable,
    output req_ready, rsp_valid, rsp_rdata, rsp_status, rsp_err,
    output spi_select, spi_mem_addr, spi_read_n, spi_write_n, spi_wdata
  );

  // Requester and SPI-core side
  modport master (
    output req_valid, req_write, req_reg, req_wdata, spi_rdata, spi_dataavailable,
    input  req_ready, rsp_valid, rsp_rdata, rsp_status, rsp_err,
    input  spi_select, spi_mem_addr, spi_read_n, spi_write_n, spi_wdata
  );
endinterface
`default_nettype wire

// File: rtl/max3421e_spi_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | max3421e_spi_sequencer: one register request -> full two-byte SPI access   |
// | of the USB host controller through the SPI master core's Avalon port.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module max3421e_spi_sequencer #(
  parameter logic [15:0] SS_MASK = 16'h0001,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  max3421e_spi_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [1:0] C_PH_GAP = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR_STAT, S_SET_SS, S_SET_SSO, S_TX_CMD, S_WAIT1, S_RD1,
    S_TX_DATA, S_WAIT2, S_RD2, S_CLR_SSO, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       status_q, status_d;
  logic             err_q, err_d;

  logic             acc_wr, acc_rd, acc_sel;
  logic [2:0]       acc_addr;
  logic [15:0]      acc_data;
  state_t           acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ph_q     <= 2'd0;
      cnt_q    <= '0;
      cmd_q    <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      status_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    err_d    = err_q;
    acc_wr   = 1'b0;
    acc_rd   = 1'b0;
    acc_addr = 3'd0;
    acc_data = 16'h0000;
    acc_next = state_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d  = S_CLR_STAT;
          ph_d     = 2'd0;
          cnt_d    = '0;
          cmd_d    = {bus.req_reg, 1'b0, bus.req_write, 1'b0};
          wdata_d  = bus.req_write ? bus.req_wdata : 8'h00;
          rdata_d  = 8'h00;
          status_d = 8'h00;
          err_d    = 1'b0;
        end
      end
      S_CLR_STAT: begin
        acc_wr = 1'b1; acc_addr = 3'd2; acc_next = S_SET_SS;
      end
      S_SET_SS: begin
        acc_wr = 1'b1; acc_addr = 3'd5; acc_data = SS_MASK; acc_next = S_SET_SSO;
      end
      S_SET_SSO: begin
        acc_wr = 1'b1; acc_addr = 3'd3; acc_data = 16'h0400; acc_next = S_TX_CMD;
      end
      S_TX_CMD: begin
        acc_wr = 1'b1; acc_addr = 3'd1; acc_data = {8'h00, cmd_q}; acc_next = S_WAIT1;
      end
      S_WAIT1, S_WAIT2: begin
        // A timeout skips straight to releasing slave-select so SS_n never sticks low.
        if (bus.spi_dataavailable) begin
          state_d = (state_q == S_WAIT1) ? S_RD1 : S_RD2;
          cnt_d   = '0;
        end else if (cnt_q == C_TIMEOUT) begin
          state_d = S_CLR_SSO;
          cnt_d   = '0;
          err_d   = 1'b1;
          rdata_d = 8'h00;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD1: begin
        acc_rd = 1'b1; acc_addr = 3'd0; acc_next = S_TX_DATA;
        if (ph_q == 2'd1) status_d = bus.spi_rdata[7:0];
      end
      S_TX_DATA: begin
        acc_wr = 1'b1; acc_addr = 3'd1; acc_data = {8'h00, wdata_q}; acc_next = S_WAIT2;
      end
      S_RD2: begin
        acc_rd = 1'b1; acc_addr = 3'd0; acc_next = S_CLR_SSO;
        if (ph_q == 2'd1) rdata_d = bus.spi_rdata[7:0];
      end
      S_CLR_SSO: begin
        acc_wr = 1'b1; acc_addr = 3'd3; acc_next = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Every core access: two strobe cycles then one idle gap cycle.
    if (acc_wr || acc_rd) begin
      if (ph_q == C_PH_GAP) begin
        ph_d    = 2'd0;
        state_d = acc_next;
      end else begin
        ph_d = ph_q + 2'd1;
      end
    end
  end

  assign acc_sel = (acc_wr || acc_rd) && (ph_q != C_PH_GAP);

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.rsp_valid    = (state_q == S_DONE);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_status   = status_q;
  assign bus.rsp_err      = err_q;
  assign bus.spi_select   = acc_sel;
  assign bus.spi_mem_addr = acc_sel ? acc_addr : 3'd0;
  assign bus.spi_read_n   = ~(acc_sel && acc_rd);
  assign bus.spi_write_n  = ~(acc_sel && acc_wr);
  assign bus.spi_wdata    = (acc_sel && acc_wr) ? acc_data : 16'h0000;

  logic unused_rdata_hi;
  assign unused_rdata_hi = ^bus.spi_rdata[15:8];

endmodule
`default_nettype wire

// File: tb/tb_max3421e_spi_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_max3421e_spi_sequencer: scoreboard bench with a transaction-level model |
// | of the controller access and a behavioural SPI-core model. Rev 1.0         |
// +----------------------------------------------------------------------------+
module tb_max3421e_spi_sequencer;
  localparam int          TIMEOUT = 16;
  localparam logic [15:0] SS_MASK = 16'h0001;

  typedef struct { int delay; logic [7:0] data; } plan_t;
  typedef struct { logic err; logic [7:0] st; logic [7:0] rd; bit lat_chk; } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned last_rsp_cyc = 0;
  int unsigned last_accept_cyc = 0;

  plan_t       core_plan[$];
  logic [19:0] exp_acc[$];
  rsp_t        exp_rsp[$];
  int unsigned acc_cyc_q[$];

  max3421e_spi_sequencer_if bus();

  max3421e_spi_sequencer #(.SS_MASK(SS_MASK), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] acc_w(input logic [2:0] a, input logic [15:0] d);
    return {1'b0, a, d};
  endfunction

  function automatic logic [19:0] acc_r(input logic [2:0] a);
    return {1'b1, a, 16'h0000};
  endfunction

  // Transaction-level model: the accesses and response one request must produce.
  // Negative delay means the core never reports the byte.
  task automatic issue(input bit wr, input logic [4:0] rg, input logic [7:0] wd,
                       input logic [7:0] st, input logic [7:0] rd,
                       input int d1, input int d2, input bit hold, input bit abort);
    bit   to1 = (d1 < 0);
    bit   to2 = !to1 && (d2 < 0);
    int   c   = int'(rg) * 8 + (wr ? 2 : 0);
    rsp_t r;
    int   n;
    exp_acc.push_back(acc_w(3'd2, 16'h0000));
    exp_acc.push_back(acc_w(3'd5, SS_MASK));
    exp_acc.push_back(acc_w(3'd3, 16'h0400));
    exp_acc.push_back(acc_w(3'd1, 16'(c)));
    core_plan.push_back('{d1, st});
    if (!to1) begin
      exp_acc.push_back(acc_r(3'd0));
      exp_acc.push_back(acc_w(3'd1, {8'h00, wr ? wd : 8'h00}));
      core_plan.push_back('{d2, rd});
      if (!to2) exp_acc.push_back(acc_r(3'd0));
    end
    if (!abort) begin
      exp_acc.push_back(acc_w(3'd3, 16'h0000));
      r.err = to1 || to2;
      r.st  = to1 ? 8'h00 : st;
      r.rd  = (to1 || to2) ? 8'h00 : rd;
      r.lat_chk = to1;
      exp_rsp.push_back(r);
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_reg   = rg;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!bus.req_ready) begin
      fails++;
      $display("FAIL accept_wait: req_ready stayed %0b, expected 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    last_accept_cyc = cyc;
    if (!abort) acc_cyc_q.push_back(cyc);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_reg   = 5'($urandom);
    bus.req_wdata = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_acc.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_rsp", 32'(exp_rsp.size()), 0);
    chk("drain_acc", 32'(exp_acc.size()), 0);
    exp_rsp.delete();
    exp_acc.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"},  32'(bus.req_ready), 1);
    chk({tag, "_rsp_valid"},  32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_rdata"},  32'(bus.rsp_rdata), 0);
    chk({tag, "_rsp_status"}, 32'(bus.rsp_status), 0);
    chk({tag, "_rsp_err"},    32'(bus.rsp_err), 0);
    chk({tag, "_select"},     32'(bus.spi_select), 0);
    chk({tag, "_read_n"},     32'(bus.spi_read_n), 1);
    chk({tag, "_write_n"},    32'(bus.spi_write_n), 1);
    chk({tag, "_addr"},       32'(bus.spi_mem_addr), 0);
    chk({tag, "_wdata"},      32'(bus.spi_wdata), 0);
  endtask

  // Behavioural SPI core: RRDY rises a planned delay after the TX write,
  // falls when the RX register is read or the status register is written.
  initial begin : core_model
    logic        c_prev;
    bit          armed;
    int          cnt;
    logic [7:0]  pend;
    plan_t       p;
    c_prev = 1'b0; armed = 1'b0; cnt = 0; pend = 8'h00;
    bus.spi_dataavailable = 1'b0;
    bus.spi_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.spi_dataavailable = 1'b0;
        armed  = 1'b0;
        c_prev = 1'b0;
        continue;
      end
      if (bus.spi_select && !c_prev) begin
        if (!bus.spi_write_n && bus.spi_mem_addr == 3'd1 && core_plan.size() != 0) begin
          p = core_plan.pop_front();
          if (p.delay >= 0) begin
            armed = 1'b1; cnt = p.delay; pend = p.data;
          end
        end
        if (!bus.spi_read_n && bus.spi_mem_addr == 3'd0) bus.spi_dataavailable = 1'b0;
        if (!bus.spi_write_n && bus.spi_mem_addr == 3'd2) bus.spi_dataavailable = 1'b0;
      end
      if (armed) begin
        if (cnt == 0) begin
          bus.spi_dataavailable = 1'b1;
          bus.spi_rdata = {8'($urandom), pend};
          armed = 1'b0;
        end else begin
          cnt--;
        end
      end
      c_prev = bus.spi_select;
    end
  end

  initial begin : monitor
    logic        prev_sel, prev_rsp;
    int          sel_len;
    logic [19:0] first_acc, obs;
    rsp_t        e;
    int unsigned ac;
    prev_sel = 1'b0; prev_rsp = 1'b0; sel_len = 0; first_acc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_sel = 1'b0; prev_rsp = 1'b0; sel_len = 0;
        continue;
      end
      obs = {~bus.spi_read_n, bus.spi_mem_addr, bus.spi_read_n ? bus.spi_wdata : 16'h0000};
      if (bus.spi_select) begin
        chk("one_strobe", 32'(bus.spi_read_n ^ bus.spi_write_n), 1);
        if (!prev_sel) begin
          sel_len   = 1;
          first_acc = obs;
          if (exp_acc.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_access: got %05h expected none", obs);
          end else begin
            chk("access", 32'(obs), 32'(exp_acc.pop_front()));
          end
        end else begin
          sel_len++;
          chk("acc_stable", 32'(obs), 32'(first_acc));
        end
      end else begin
        if (prev_sel) chk("acc_len", 32'(sel_len), 2);
        chk("idle_strobes", 32'({bus.spi_read_n, bus.spi_write_n}), 3);
      end
      prev_sel = bus.spi_select;

      if (bus.rsp_valid) begin
        chk("rsp_single", 32'(prev_rsp), 0);
        last_rsp_cyc = cyc;
        if (exp_rsp.size() == 0 || acc_cyc_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
        end else begin
          e  = exp_rsp.pop_front();
          ac = acc_cyc_q.pop_front();
          chk("rsp_err",    32'(bus.rsp_err),    32'(e.err));
          chk("rsp_status", 32'(bus.rsp_status), 32'(e.st));
          chk("rsp_rdata",  32'(bus.rsp_rdata),  32'(e.rd));
          if (e.lat_chk) begin
            tests++;
            if (cyc - ac < TIMEOUT + 16 || cyc - ac > TIMEOUT + 17) begin
              fails++;
              $display("FAIL timeout_latency: got %0d expected %0d..%0d",
                       cyc - ac, TIMEOUT + 16, TIMEOUT + 17);
            end
          end
        end
      end
      prev_rsp = bus.rsp_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of run, expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int sel_seen;
    int d1, d2;
    bit hold;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_reg   = 5'd0;
    bus.req_wdata = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    sel_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.spi_select) sel_seen++;
    end
    chk("idle_no_select", 32'(sel_seen), 0);
    check_reset_values("idle");

    // Read reg 18: cmd 0x90, status 0x5A, data 0x3C.
    issue(1'b0, 5'd18, 8'h77, 8'h5A, 8'h3C, 3, 5, 1'b0, 1'b0);
    wait_done();
    // Write reg 17 with 0x01: cmd 0x8A; RRDY already up on the first WAIT cycle.
    issue(1'b1, 5'd17, 8'h01, 8'hC4, 8'hE1, 0, 0, 1'b0, 1'b0);
    wait_done();
    // Timeout in the command phase.
    issue(1'b0, 5'd5, 8'h00, 8'h11, 8'h22, -1, 0, 1'b0, 1'b0);
    wait_done();
    // Timeout in the data phase keeps the status byte.
    issue(1'b1, 5'd9, 8'hC3, 8'h66, 8'h99, 2, -1, 1'b0, 1'b0);
    wait_done();

    // req_valid held across two requests.
    issue(1'b1, 5'd3, 8'hA5, 8'h12, 8'h34, 4, 6, 1'b1, 1'b0);
    issue(1'b0, 5'd30, 8'hFF, 8'h56, 8'h78, 1, 2, 1'b0, 1'b0);
    chk("b2b_accept_cycle", 32'(last_accept_cyc), 32'(last_rsp_cyc + 1));
    wait_done();

    for (int i = 0; i < 25; i++) begin
      d1   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
      d2   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
      hold = ($urandom_range(0, 2) == 0);
      issue(1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            d1, d2, hold, 1'b0);
    end
    bus.req_valid = 1'b0;
    wait_done();

    // Reset while waiting for the data byte.
    issue(1'b1, 5'd21, 8'h3E, 8'hAB, 8'hCD, 2, -1, 1'b0, 1'b1);
    begin
      int n = 0;
      while (exp_acc.size() != 0 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("abort_prefix", 32'(exp_acc.size()), 0);
    end
    repeat (5) @(negedge clk);
    chk("abort_in_wait_select", 32'(bus.spi_select), 0);
    reset = 1'b1;
    core_plan.delete();
    @(negedge clk);
    check_reset_values("abort");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_rsp_pending", 32'(exp_rsp.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
